// File: rtl/sobel_gradient_pkg.sv
// Shared types for the Canny pipeline stages.
//   pixel_t        8-bit grayscale pixel
//   sobel_state_t  sobel_gradient FSM states
//   DEF_WIDTH/HEIGHT default frame geometry
package canny_pkg;
  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } sobel_state_t;

  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 720;
endpackage

// File: rtl/sobel_gradient_if.sv
// FIFO-facing bundle of the Sobel stage.
//   in_empty/in_rd_en/in_dout    upstream FWFT FIFO (pop side)
//   out_full/out_wr_en/out_din   downstream FIFO (push side)
// master: the surrounding FIFOs; slave: the sobel_gradient block.
interface sobel_gradient_if;
  import canny_pkg::*;

  logic   in_empty;
  logic   in_rd_en;
  pixel_t in_dout;
  logic   out_full;
  logic   out_wr_en;
  pixel_t out_din;

  modport master (output in_empty, in_dout, out_full,
                  input  in_rd_en, out_wr_en, out_din);
  modport slave  (input  in_empty, in_dout, out_full,
                  output in_rd_en, out_wr_en, out_din);
endinterface

// File: rtl/sobel_gradient_kernel.sv
// sobel_kernel: combinational 3x3 Sobel magnitude.
//   p    3x3 window, p[row][col], row 0 = top (oldest), col 0 = left
//   mag  min((|gx|+|gy|)>>1, 255)
module sobel_kernel
  import canny_pkg::*;
(
  input  pixel_t [2:0][2:0] p,
  output pixel_t            mag
);
  // Weighted column/row sums peak at 4*255 = 1020, so 10 bits suffice.
  logic [9:0]         xr, xl, yb, yt;
  logic signed [10:0] gx, gy;
  logic [10:0]        ax, ay;
  logic [11:0]        sum;

  always_comb begin
    xr  = 10'(p[0][2]) + 10'({p[1][2], 1'b0}) + 10'(p[2][2]);
    xl  = 10'(p[0][0]) + 10'({p[1][0], 1'b0}) + 10'(p[2][0]);
    yb  = 10'(p[2][0]) + 10'({p[2][1], 1'b0}) + 10'(p[2][2]);
    yt  = 10'(p[0][0]) + 10'({p[0][1], 1'b0}) + 10'(p[0][2]);
    gx  = $signed({1'b0, xr}) - $signed({1'b0, xl});
    gy  = $signed({1'b0, yb}) - $signed({1'b0, yt});
    ax  = gx[10] ? 11'(-gx) : 11'(gx);
    ay  = gy[10] ? 11'(-gy) : 11'(gy);
    sum = {1'b0, ax} + {1'b0, ay};
    // sum>>1 above 255 saturates; compare on the unshifted sum.
    mag = (sum > 12'd511) ? 8'hFF : sum[8:1];
  end
endmodule

// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel magnitude, one output per input pixel,
// zeroed image borders.
//   clock  system clock
//   reset  asynchronous, active-low
//   bus    sobel_gradient_if.slave (upstream FWFT pop, downstream push)
module sobel_gradient
  import canny_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input logic          clock,
  input logic          reset,
  sobel_gradient_if.slave bus
);
  localparam int BL   = 2*WIDTH + 3;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(NPIX);
  localparam int XW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);

  sobel_state_t       state;
  pixel_t [BL-1:0]    sbuf, nbuf;
  logic [CW-1:0]      in_count;
  logic [XW-1:0]      col;
  logic [RW-1:0]      row;
  pixel_t             out_q;
  logic               out_valid;

  logic               advance, accept, step, produce, border;
  pixel_t             shift_px, mag;
  pixel_t [2:0][2:0]  win;

  always_comb begin
    advance = ~out_valid | ~bus.out_full;
    case (state)
      S_FILL:  bus.in_rd_en = ~bus.in_empty & reset;
      S_RUN:   bus.in_rd_en = ~bus.in_empty & advance & reset;
      default: bus.in_rd_en = 1'b0;
    endcase
    accept  = bus.in_rd_en;
    produce = (state == S_RUN & accept) | (state == S_FLUSH & advance);
    step    = accept | (state == S_FLUSH & advance);
    // Flush steps push zeros so the last rows' windows complete.
    shift_px = accept ? bus.in_dout : '0;
    nbuf     = {sbuf[BL-2:0], shift_px};
    // The kernel sees the buffer as it will be after this shift, so the
    // result registers on the same edge that accepts pixel n+WIDTH+1.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = nbuf[(2-r)*WIDTH + (2-c)];
    border = (row == '0) | (row == RW'(HEIGHT-1)) |
             (col == '0) | (col == XW'(WIDTH-1));
  end

  sobel_kernel u_kernel (.p(win), .mag(mag));

  assign bus.out_wr_en = out_valid & ~bus.out_full & reset;
  assign bus.out_din   = out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_FILL;
      sbuf      <= '0;
      in_count  <= '0;
      col       <= '0;
      row       <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (step) sbuf <= nbuf;

      if (produce) begin
        out_q     <= border ? 8'd0 : mag;
        out_valid <= 1'b1;
        if (col == XW'(WIDTH-1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (bus.out_wr_en) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_FILL: if (accept) begin
          in_count <= in_count + 1'b1;
          if (in_count == CW'(WIDTH)) state <= S_RUN;
        end
        S_RUN: if (accept) begin
          if (in_count == CW'(NPIX-1)) begin
            in_count <= '0;
            state    <= S_FLUSH;
          end else begin
            in_count <= in_count + 1'b1;
          end
        end
        S_FLUSH: begin
          // Final result of the frame is the bottom-right pixel; row/col
          // wrap to 0 on this same step.
          if (advance && row == RW'(HEIGHT-1) && col == XW'(WIDTH-1))
            state <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_gradient.sv
module tb_sobel_gradient;
  import canny_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  sobel_gradient_if intf ();

  sobel_gradient #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int fails  = 0;
  int img [H][W];
  int in_q[$];
  int exp_q[$];
  int pushes = 0;
  int pops   = 0;
  bit stall_in  = 1'b0;
  bit stall_out = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: Sobel on the whole image held in img, border forced to 0.
  function automatic int golden(input int r, input int c);
    int gx, gy, m;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic set_const(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic set_step(input int hi);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? hi : 0;
  endtask

  task automatic load_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        in_q.push_back(img[r][c]);
        exp_q.push_back(golden(r, c));
      end
  endtask

  task automatic drain(input string name, input int base, input int count);
    int n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (12) @(negedge clock);
    check({name, "_count"}, pushes - base, count);
  endtask

  // Upstream FWFT FIFO and downstream full emulation.
  initial begin
    bit pop;
    intf.in_empty = 1'b1;
    intf.in_dout  = '0;
    intf.out_full = 1'b0;
    forever begin
      @(negedge clock);
      intf.out_full = stall_out && ($urandom_range(0, 9) < 3);
      intf.in_empty = (in_q.size() == 0) || (stall_in && $urandom_range(0, 3) == 0);
      intf.in_dout  = (in_q.size() != 0) ? 8'(in_q[0]) : 8'd0;
      #1;
      pop = intf.in_rd_en;
      @(posedge clock);
      if (pop && in_q.size() != 0) begin
        void'(in_q.pop_front());
        pops++;
      end
    end
  end

  // Output scoreboard: every push must match the next expected pixel.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        check("reset_quiet", {30'd0, intf.out_wr_en, intf.in_rd_en}, 0);
      end else if (intf.out_wr_en) begin
        pushes++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_output: got push of %0d, expected no push", intf.out_din);
        end else begin
          check("pixel", int'(intf.out_din), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int base, n;
    repeat (3) @(negedge clock);
    #3;
    check("reset_out_din", int'(intf.out_din), 0);
    check("reset_wr_en", int'(intf.out_wr_en), 0);
    @(negedge clock);
    reset = 1'b1;

    // Constant image: all outputs zero.
    set_const(100);
    check("pin_const", golden(2, 3), 0);
    base = pushes; load_frame(); drain("const", base, 48);

    // Vertical step 0|40.
    set_step(40);
    check("pin_step_c3", golden(2, 3), 80);
    check("pin_step_c4", golden(3, 4), 80);
    check("pin_step_c5", golden(2, 5), 0);
    check("pin_step_row0", golden(0, 3), 0);
    base = pushes; load_frame(); drain("step40", base, 48);

    // Vertical step 0|255 saturates.
    set_step(255);
    check("pin_sat", golden(4, 4), 255);
    base = pushes; load_frame(); drain("step255", base, 48);

    // Random image under random stalls on both sides.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
    stall_in = 1'b1; stall_out = 1'b1;
    base = pushes; load_frame(); drain("random", base, 48);
    stall_in = 1'b0; stall_out = 1'b0;

    // Back-to-back frames: step, then constant.
    base = pushes;
    set_step(40);   load_frame();
    set_const(100); load_frame();
    drain("b2b", base, 96);

    // Reset after 20 inputs of a frame.
    set_const(50);
    for (int i = 0; i < 20; i++) in_q.push_back(50);
    for (int i = 0; i < W*H; i++) exp_q.push_back(0);
    base = pops; n = 0;
    while (pops - base < 20 && n < 500) begin @(negedge clock); n++; end
    check("partial_pops", pops - base, 20);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #3;
    exp_q.delete();
    in_q.delete();
    repeat (6) @(negedge clock);
    reset = 1'b1;
    base = pushes; load_frame(); drain("after_reset", base, 48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
